poly_key_synth: RTL and testbench

//  Polyphonic successor to the single-tone keyboard synth: consumes PS/2 scan-code bytes, decodes make/break
//  (F0) and extended (E0) prefixes, assigns pressed notes to NUM_VOICES square-wave voices, and mixes all

---
 rtl/poly_key_synth.sv | 217 +++++++++++++++++++++
 tb/tb_poly_key_synth.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_key_synth.sv
// Polyphonic PS/2 keyboard synth: scan-code decoder, voice allocator with round-robin
// stealing, per-voice square-wave tone generators and a PWM mixer driving one speaker bit.

module pks_tone #(
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_sq
);
    logic [DIV_W-1:0] r_cnt;
    logic             r_sq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sq  <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sq  <= 1'b0;
        end else if (r_cnt == i_period - DIV_W'(1)) begin
            r_cnt <= '0;
            r_sq  <= ~r_sq;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign o_sq = r_sq;
endmodule

module poly_key_synth #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_scan_valid,
    input  logic [7:0]            i_scan_code,
    output logic                  o_speaker,
    output logic                  o_play_sound,
    output logic [NUM_VOICES-1:0] o_voice_active,
    output logic [1:0]            o_octave,
    output logic [2:0]            o_last_note
);
    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SW = $clog2(NUM_VOICES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BRK     = 2'd1;
    localparam logic [1:0] S_EXT     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]                             r_state;
    logic [1:0]                             r_octave;
    logic [2:0]                             r_last_note;
    logic [NUM_VOICES-1:0]                  r_active;
    logic [NUM_VOICES-1:0][2:0]             r_note;
    logic [NUM_VOICES-1:0][DIV_W-1:0]       r_period;
    logic [PW-1:0]                          r_steal_ptr;
    logic [PW-1:0]                          r_pwm_cnt;
    logic                                   r_speaker;

    logic                  w_key_hit;
    logic [2:0]            w_key_idx;
    logic [DIV_W-1:0]      w_base;
    logic                  w_is_make;
    logic                  w_is_brk;
    logic [NUM_VOICES-1:0] w_hit_v;
    logic                  w_free_found;
    logic [PW-1:0]         w_free_idx;
    logic                  w_alloc;
    logic [PW-1:0]         w_tgt;
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_kill;
    logic [NUM_VOICES-1:0] w_clr;
    logic [NUM_VOICES-1:0] w_sq;
    logic [SW-1:0]         w_sum;

    always_comb begin
        w_key_hit = 1'b1;
        w_key_idx = 3'd0;
        case (i_scan_code)
            8'h1C:   w_key_idx = 3'd0;
            8'h1B:   w_key_idx = 3'd1;
            8'h23:   w_key_idx = 3'd2;
            8'h2B:   w_key_idx = 3'd3;
            8'h34:   w_key_idx = 3'd4;
            8'h33:   w_key_idx = 3'd5;
            8'h3B:   w_key_idx = 3'd6;
            8'h42:   w_key_idx = 3'd7;
            default: w_key_hit = 1'b0;
        endcase
    end

    // Half-periods at octave 0 for a 100 MHz clock
    always_comb begin
        case (w_key_idx)
            3'd0:    w_base = DIV_W'(191109);
            3'd1:    w_base = DIV_W'(170265);
            3'd2:    w_base = DIV_W'(151685);
            3'd3:    w_base = DIV_W'(143172);
            3'd4:    w_base = DIV_W'(127550);
            3'd5:    w_base = DIV_W'(113636);
            3'd6:    w_base = DIV_W'(101238);
            default: w_base = DIV_W'(95556);
        endcase
    end

    assign w_is_make = i_scan_valid && (r_state == S_IDLE) &&
                       (i_scan_code != 8'hF0) && (i_scan_code != 8'hE0);
    assign w_is_brk  = i_scan_valid && (r_state == S_BRK);

    // Descending scan so the lowest-index idle voice wins
    always_comb begin
        w_hit_v      = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            w_hit_v[v] = r_active[v] && (r_note[v] == w_key_idx);
            if (!r_active[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = PW'(v);
            end
        end
    end

    assign w_alloc = w_is_make && w_key_hit && !(|w_hit_v);
    assign w_tgt   = w_free_found ? w_free_idx : r_steal_ptr;

    always_comb begin
        w_load = '0;
        w_kill = '0;
        w_clr  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_load[v] = w_alloc && (w_tgt == PW'(v));
            w_kill[v] = w_is_brk && w_key_hit && w_hit_v[v];
            w_clr[v]  = w_load[v] || w_kill[v] || !r_active[v];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_octave    <= 2'd0;
            r_last_note <= 3'd0;
            r_active    <= '0;
            r_note      <= '0;
            r_period    <= '0;
            r_steal_ptr <= '0;
        end else begin
            if (i_scan_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_scan_code == 8'hF0)      r_state <= S_BRK;
                        else if (i_scan_code == 8'hE0) r_state <= S_EXT;
                    end
                    S_EXT:   r_state <= (i_scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
            if (w_is_make && (i_scan_code == 8'h4E) && (r_octave != 2'd0))
                r_octave <= r_octave - 2'd1;
            if (w_is_make && (i_scan_code == 8'h55) && (r_octave != 2'd2))
                r_octave <= r_octave + 2'd1;
            if (w_alloc) begin
                r_last_note <= w_key_idx;
                if (!w_free_found)
                    r_steal_ptr <= (r_steal_ptr == PW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + PW'(1);
            end
            // Period is latched at allocation, so later octave changes leave sounding voices alone
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_load[v]) begin
                    r_active[v] <= 1'b1;
                    r_note[v]   <= w_key_idx;
                    r_period[v] <= w_base >> r_octave;
                end else if (w_kill[v]) begin
                    r_active[v] <= 1'b0;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        pks_tone #(.DIV_W(DIV_W)) u_tone (
            .clk      (clk),
            .rst      (rst),
            .i_clr    (w_clr[v]),
            .i_period (r_period[v]),
            .o_sq     (w_sq[v])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            w_sum = w_sum + SW'(r_active[v] & w_sq[v]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_speaker <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PW'(NUM_VOICES - 1)) ? '0 : r_pwm_cnt + PW'(1);
            r_speaker <= (SW'(r_pwm_cnt) < w_sum);
        end
    end

    assign o_speaker      = r_speaker;
    assign o_play_sound   = |r_active;
    assign o_voice_active = r_active;
    assign o_octave       = r_octave;
    assign o_last_note    = r_last_note;
endmodule

// File: tb/tb_poly_key_synth.sv
// Directed bench for poly_key_synth: a 4-voice instance plus 1- and 2-voice instances
// sharing the same byte stream, used to observe tone timing and PWM duty directly.

module tb_poly_key_synth;
    logic       clk;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;

    logic       spk4, ps4;
    logic [3:0] va4;
    logic [1:0] oct4;
    logic [2:0] ln4;
    logic       spk1, ps1;
    logic [0:0] va1;
    logic [1:0] oct1;
    logic [2:0] ln1;
    logic       spk2, ps2;
    logic [1:0] va2;
    logic [1:0] oct2;
    logic [2:0] ln2;

    int checks = 0;
    int errors = 0;

    poly_key_synth #(.NUM_VOICES(4), .DIV_W(18)) u_dut (
        .clk(clk), .rst(rst), .i_scan_valid(scan_valid), .i_scan_code(scan_code),
        .o_speaker(spk4), .o_play_sound(ps4), .o_voice_active(va4),
        .o_octave(oct4), .o_last_note(ln4)
    );

    poly_key_synth #(.NUM_VOICES(1), .DIV_W(18)) u_dut1 (
        .clk(clk), .rst(rst), .i_scan_valid(scan_valid), .i_scan_code(scan_code),
        .o_speaker(spk1), .o_play_sound(ps1), .o_voice_active(va1),
        .o_octave(oct1), .o_last_note(ln1)
    );

    poly_key_synth #(.NUM_VOICES(2), .DIV_W(18)) u_dut2 (
        .clk(clk), .rst(rst), .i_scan_valid(scan_valid), .i_scan_code(scan_code),
        .o_speaker(spk2), .o_play_sound(ps2), .o_voice_active(va2),
        .o_octave(oct2), .o_last_note(ln2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({spk4, ps4, va4, oct4, ln4} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got spk=%b ps=%b va=%b oct=%0d ln=%0d, expected all 0",
                     spk4, ps4, va4, oct4, ln4);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({spk1, spk2, ps1, ps2} !== 4'd0) begin
            errors++;
            $display("FAIL reset_small: got spk1=%b spk2=%b ps1=%b ps2=%b, expected 0", spk1, spk2, ps1, ps2);
        end
    endtask

    task automatic test_single_note();
        int cyc;
        do_reset();
        send(8'h1C);
        checks++;
        if (va4 !== 4'b0001 || ln4 !== 3'd0 || ps4 !== 1'b1) begin
            errors++;
            $display("FAIL single_alloc: got va=%b ln=%0d ps=%b, expected 0001 0 1", va4, ln4, ps4);
        end
        send(8'h15);
        checks++;
        if (va4 !== 4'b0001 || ln4 !== 3'd0) begin
            errors++;
            $display("FAIL unmapped_ignored: got va=%b ln=%0d, expected 0001 0", va4, ln4);
        end
        // Note 42 at octave 2: half-period 95556>>2 = 23889, speaker registered one clk later
        do_reset();
        send(8'h55);
        send(8'h55);
        send(8'h42);
        cyc = 0;
        while (spk1 !== 1'b1 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 23890) begin
            errors++;
            $display("FAIL tone_rise_delay: got %0d clk, expected 23890", cyc);
        end
    endtask

    task automatic test_break();
        do_reset();
        send(8'h1C);
        send(8'hF0);
        checks++;
        if (va4 !== 4'b0001) begin
            errors++;
            $display("FAIL break_prefix_only: got va=%b, expected 0001", va4);
        end
        send(8'h1C);
        checks++;
        if (va4 !== 4'b0000 || ps4 !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got va=%b ps=%b, expected 0000 0", va4, ps4);
        end
        @(negedge clk);
        checks++;
        if (spk4 !== 1'b0) begin
            errors++;
            $display("FAIL break_speaker: got %b, expected 0", spk4);
        end
    endtask

    task automatic test_steal();
        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        checks++;
        if (va4 !== 4'b1111 || ln4 !== 3'd3) begin
            errors++;
            $display("FAIL steal_fill: got va=%b ln=%0d, expected 1111 3", va4, ln4);
        end
        send(8'h34);
        checks++;
        if (va4 !== 4'b1111 || ln4 !== 3'd4) begin
            errors++;
            $display("FAIL steal_first: got va=%b ln=%0d, expected 1111 4", va4, ln4);
        end
        send(8'hF0); send(8'h1C);
        checks++;
        if (va4 !== 4'b1111) begin
            errors++;
            $display("FAIL steal_stolen_break: got va=%b, expected 1111", va4);
        end
        send(8'h1C);
        send(8'h1B);
        checks++;
        if (ln4 !== 3'd1) begin
            errors++;
            $display("FAIL steal_chain: got ln=%0d, expected 1", ln4);
        end
        send(8'h1C);
        checks++;
        if (ln4 !== 3'd1 || va4 !== 4'b1111) begin
            errors++;
            $display("FAIL typematic_repeat: got ln=%0d va=%b, expected 1 1111", ln4, va4);
        end
        send(8'hF0); send(8'h23);
        checks++;
        if (va4 !== 4'b1111) begin
            errors++;
            $display("FAIL steal_note2_gone: got va=%b, expected 1111", va4);
        end
        // voice0=note4, voice1=note0, voice2=note1, voice3=note3
        send(8'hF0); send(8'h34);
        checks++;
        if (va4 !== 4'b1110) begin
            errors++;
            $display("FAIL steal_map_v0: got va=%b, expected 1110", va4);
        end
        send(8'hF0); send(8'h1C);
        checks++;
        if (va4 !== 4'b1100) begin
            errors++;
            $display("FAIL steal_map_v1: got va=%b, expected 1100", va4);
        end
        send(8'hF0); send(8'h1B);
        checks++;
        if (va4 !== 4'b1000) begin
            errors++;
            $display("FAIL steal_map_v2: got va=%b, expected 1000", va4);
        end
        send(8'hF0); send(8'h2B);
        checks++;
        if (va4 !== 4'b0000 || ps4 !== 1'b0) begin
            errors++;
            $display("FAIL steal_map_v3: got va=%b ps=%b, expected 0000 0", va4, ps4);
        end
    endtask

    task automatic test_octave();
        do_reset();
        send(8'h55); send(8'h55); send(8'h55);
        checks++;
        if (oct4 !== 2'd2) begin
            errors++;
            $display("FAIL octave_sat_hi: got %0d, expected 2", oct4);
        end
        send(8'h33);
        checks++;
        if (u_dut.r_period[0] !== 18'd28409 || ln4 !== 3'd5) begin
            errors++;
            $display("FAIL octave_period: got period=%0d ln=%0d, expected 28409 5", u_dut.r_period[0], ln4);
        end
        send(8'hF0); send(8'h55);
        checks++;
        if (oct4 !== 2'd2) begin
            errors++;
            $display("FAIL octave_break_ignored: got %0d, expected 2", oct4);
        end
        send(8'h4E);
        checks++;
        if (oct4 !== 2'd1) begin
            errors++;
            $display("FAIL octave_dec: got %0d, expected 1", oct4);
        end
        send(8'h4E); send(8'h4E);
        checks++;
        if (oct4 !== 2'd0 || u_dut.r_period[0] !== 18'd28409) begin
            errors++;
            $display("FAIL octave_sat_lo: got oct=%0d period=%0d, expected 0 28409", oct4, u_dut.r_period[0]);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h1C);
        checks++;
        if (va4 !== 4'b0000) begin
            errors++;
            $display("FAIL ext_make_discard: got va=%b, expected 0000", va4);
        end
        send(8'hE0); send(8'hF0); send(8'h1C);
        checks++;
        if (va4 !== 4'b0000) begin
            errors++;
            $display("FAIL ext_break_discard: got va=%b, expected 0000", va4);
        end
        send(8'h1B);
        checks++;
        if (va4 !== 4'b0001 || ln4 !== 3'd1) begin
            errors++;
            $display("FAIL ext_back_idle: got va=%b ln=%0d, expected 0001 1", va4, ln4);
        end
    endtask

    task automatic test_mix();
        int c;
        int h2;
        int h4;
        do_reset();
        send(8'h55); send(8'h55);
        send(8'h3B);                      // half-period 25309
        c = 0;
        repeat (700) @(negedge clk);
        c += 700;
        send(8'h42);                      // half-period 23889, latched 702 clk after 3B
        c += 2;
        checks++;
        if (va4 !== 4'b0011 || va2 !== 2'b11) begin
            errors++;
            $display("FAIL mix_alloc: got va4=%b va2=%b, expected 0011 11", va4, va2);
        end
        repeat (1000 - c) @(negedge clk);
        c = 1000;
        h2 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            h2 += int'(spk2);
        end
        c += 100;
        checks++;
        if (h2 != 0) begin
            errors++;
            $display("FAIL mix_duty0: got %0d high of 100, expected 0", h2);
        end
        repeat (24800 - c) @(negedge clk);
        c = 24800;
        h2 = 0;
        h4 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            h2 += int'(spk2);
            h4 += int'(spk4);
        end
        c += 100;
        checks++;
        if (h2 != 50 || h4 != 25) begin
            errors++;
            $display("FAIL mix_duty50: got n2=%0d n4=%0d high of 100, expected 50 25", h2, h4);
        end
        repeat (25500 - c) @(negedge clk);
        h2 = 0;
        h4 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            h2 += int'(spk2);
            h4 += int'(spk4);
        end
        checks++;
        if (h2 != 100 || h4 != 50) begin
            errors++;
            $display("FAIL mix_duty100: got n2=%0d n4=%0d high of 100, expected 100 50", h2, h4);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({spk4, ps4, va4, oct4, ln4, spk2, ps2, va2} !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got spk=%b ps=%b va=%b oct=%0d ln=%0d spk2=%b, expected all 0",
                     spk4, ps4, va4, oct4, ln4, spk2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        test_reset();
        test_single_note();
        test_break();
        test_steal();
        test_octave();
        test_extended();
        test_mix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
